// File: rtl/sky130_ef_io_gpio_cfg_chain.sv
// Serial configuration chain for a bank of gpiov2 pads: shifts config into a shadow
// chain and commits it to the pads under a hold window (hold, commit, release).
module sky130_ef_io_gpio_cfg_chain #(
    parameter int                     NUM_PADS    = 4,
    parameter int                     CFG_BITS    = 13,
    parameter logic [CFG_BITS-1:0]    DEFAULT_CFG = 13'h0403,
    parameter int                     HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ser_en,
    input  logic                         ser_data,
    output logic                         ser_out,
    input  logic                         load,
    output logic [NUM_PADS*CFG_BITS-1:0] cfg_out,
    output logic [NUM_PADS-1:0]          hld_h_n,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int TOTAL = NUM_PADS * CFG_BITS;
    localparam int CNT_W = $clog2(TOTAL + 2);
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_TOTAL   = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_OVF     = CNT_W'(TOTAL + 1);
    localparam logic [HC_W-1:0]  HC_LAST     = HC_W'(HOLD_CYCLES - 1);
    localparam logic [TOTAL-1:0] RESET_CHAIN = {NUM_PADS{DEFAULT_CFG}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_PRE  = 2'd1,
        ST_APPLY     = 2'd2,
        ST_HOLD_POST = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HC_W-1:0]   r_hcnt;
    logic [HC_W-1:0]   w_hcnt_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [TOTAL-1:0]  r_shadow;
    logic [TOTAL-1:0]  r_cfg;
    logic [NUM_PADS-1:0] r_hld_n;
    logic              r_busy;
    logic              r_cfg_err;
    logic              w_shift;
    logic              w_load_ok;
    logic              w_load_bad;

    // Next-state and request decode; load wins over ser_en, both ignored while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_shift     = 1'b0;
        w_load_ok   = 1'b0;
        w_load_bad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hcnt_nxt = '0;
                if (load) begin
                    if (r_cnt == CNT_TOTAL) begin
                        w_load_ok   = 1'b1;
                        w_state_nxt = ST_HOLD_PRE;
                    end else begin
                        w_load_bad  = 1'b1;
                    end
                end else if (ser_en) begin
                    w_shift = 1'b1;
                end else begin
                    w_shift = 1'b0;
                end
            end
            ST_HOLD_PRE: begin
                if (r_hcnt == HC_LAST) begin
                    w_state_nxt = ST_APPLY;
                    w_hcnt_nxt  = '0;
                end else begin
                    w_hcnt_nxt  = r_hcnt + HC_W'(1);
                end
            end
            ST_APPLY: begin
                w_state_nxt = ST_HOLD_POST;
                w_hcnt_nxt  = '0;
            end
            ST_HOLD_POST: begin
                if (r_hcnt == HC_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                end else begin
                    w_hcnt_nxt  = r_hcnt + HC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hcnt_nxt  = '0;
            end
        endcase
    end

    // Sequencer state; hold and busy are registered from the next state so they
    // line up exactly with the non-idle states.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_busy  <= 1'b0;
            r_hld_n <= {NUM_PADS{1'b1}};
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_hld_n <= {NUM_PADS{w_state_nxt == ST_IDLE}};
        end
    end

    // Shadow chain and bit counter; the counter parks at TOTAL+1 to flag overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shadow  <= RESET_CHAIN;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shadow <= {r_shadow[TOTAL-2:0], ser_data};
                if (r_cnt != CNT_OVF) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_load_ok || w_load_bad) begin
                r_cnt <= '0;
            end
            if (w_load_ok) begin
                r_cfg_err <= 1'b0;
            end else if (w_load_bad) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // Active configuration only moves in the middle of the hold window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cfg <= RESET_CHAIN;
        end else if (r_state == ST_APPLY) begin
            r_cfg <= r_shadow;
        end
    end

    assign ser_out = r_shadow[TOTAL-1];
    assign cfg_out = r_cfg;
    assign hld_h_n = r_hld_n;
    assign busy    = r_busy;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_sky130_ef_io_gpio_cfg_chain.sv
// Directed bench for the gpio config chain: table of shift/load vectors plus
// hand sequences for busy-time inputs and reset during the hold window.
module tb_sky130_ef_io_gpio_cfg_chain;

    localparam int NP  = 2;
    localparam int CB  = 4;
    localparam int HC  = 2;
    localparam int TOT = NP * CB;

    logic             clk = 1'b0;
    logic             resetn;
    logic             ser_en;
    logic             ser_data;
    logic             load;
    logic             ser_out;
    logic [TOT-1:0]   cfg_out;
    logic [NP-1:0]    hld_h_n;
    logic             busy;
    logic             cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    sky130_ef_io_gpio_cfg_chain #(
        .NUM_PADS(NP), .CFG_BITS(CB), .DEFAULT_CFG(4'h3), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk), .resetn(resetn), .ser_en(ser_en), .ser_data(ser_data),
        .ser_out(ser_out), .load(load), .cfg_out(cfg_out), .hld_h_n(hld_h_n),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nbits;
        logic [15:0] data;
        logic        en_on_load;
        logic        commit;
        logic [7:0]  cfg;
        logic        err;
        logic        so;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_bits(input int n, input logic [15:0] d);
        for (int i = n - 1; i >= 0; i--) begin
            ser_en   = 1'b1;
            ser_data = d[i];
            @(posedge clk); #1;
        end
        ser_en   = 1'b0;
        ser_data = 1'b0;
    endtask

    task automatic do_load(input logic en);
        load     = 1'b1;
        ser_en   = en;
        ser_data = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
        ser_en   = 1'b0;
        ser_data = 1'b0;
    endtask

    // Observe the hold window following a load: length, busy length and cfg timing.
    task automatic watch_hold(input string tag, input logic [7:0] old_cfg,
                              input logic [7:0] new_cfg, input logic commit);
        int low = 0;
        int bsy = 0;
        for (int c = 0; c < 2 * HC + 4; c++) begin
            if (hld_h_n == 2'b00) begin
                low++;
                if (low == 1)      check({tag, " cfg first hold"}, cfg_out, old_cfg);
                if (low == HC + 1) check({tag, " cfg before apply"}, cfg_out, old_cfg);
                if (low == HC + 2) check({tag, " cfg after apply"}, cfg_out, new_cfg);
                if (low == 2*HC+1) check({tag, " cfg last hold"}, cfg_out, new_cfg);
            end else if (hld_h_n != 2'b11) begin
                check({tag, " hld all-or-none"}, hld_h_n, 2'b11);
            end
            if (busy) bsy++;
            @(posedge clk); #1;
        end
        check({tag, " hold cycles"}, low, commit ? 2 * HC + 1 : 0);
        check({tag, " busy cycles"}, bsy, commit ? 2 * HC + 1 : 0);
    endtask

    initial begin
        logic [7:0] cur_cfg;
        int k;

        vecs[0] = '{8, 16'h00A5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
        vecs[1] = '{7, 16'h0012, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[2] = '{8, 16'h003C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{9, 16'h00F0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1};
        vecs[4] = '{8, 16'h005A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[5] = '{0, 16'h0000, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[6] = '{8, 16'h00C3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};

        resetn = 1'b0; ser_en = 1'b0; ser_data = 1'b0; load = 1'b0;
        #12;
        check("cfg in reset", cfg_out, 8'h33);
        resetn = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("reset cfg_out", cfg_out, 8'h33);
        check("reset hld_h_n", hld_h_n, 2'b11);
        check("reset busy", busy, 1'b0);
        check("reset cfg_err", cfg_err, 1'b0);
        check("reset ser_out", ser_out, 1'b0);

        cur_cfg = 8'h33;
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            shift_bits(vecs[i].nbits, vecs[i].data);
            do_load(vecs[i].en_on_load);
            watch_hold(tag, cur_cfg, vecs[i].cfg, vecs[i].commit);
            check({tag, " cfg_out"}, cfg_out, vecs[i].cfg);
            check({tag, " cfg_err"}, cfg_err, vecs[i].err);
            check({tag, " ser_out"}, ser_out, vecs[i].so);
            check({tag, " hld idle"}, hld_h_n, 2'b11);
            check({tag, " busy idle"}, busy, 1'b0);
            cur_cfg = vecs[i].cfg;
        end

        // Inputs toggled while busy must not shift, count, commit or flag errors.
        shift_bits(8, 16'h0069);
        do_load(1'b0);
        k = 0;
        while (busy && k < 20) begin
            ser_en   = ~ser_en;
            ser_data = 1'b1;
            load     = k[0];
            @(posedge clk); #1;
            k++;
        end
        ser_en = 1'b0; load = 1'b0; ser_data = 1'b0;
        check("busy bounded", busy, 1'b0);
        check("busy cfg_out", cfg_out, 8'h69);
        check("busy cfg_err", cfg_err, 1'b0);
        shift_bits(8, 16'h0096);
        do_load(1'b0);
        watch_hold("after busy", 8'h69, 8'h96, 1'b1);
        check("after busy cfg_out", cfg_out, 8'h96);
        check("after busy cfg_err", cfg_err, 1'b0);

        // Reset asserted in the post-commit hold window.
        shift_bits(8, 16'h005A);
        do_load(1'b0);
        repeat (HC + 1) begin @(posedge clk); #1; end
        check("post hold low", hld_h_n, 2'b00);
        check("post cfg new", cfg_out, 8'h5A);
        #2 resetn = 1'b0;
        #1;
        check("async rst hld", hld_h_n, 2'b11);
        check("async rst cfg", cfg_out, 8'h33);
        check("async rst busy", busy, 1'b0);
        check("async rst ser_out", ser_out, 1'b0);
        #3 resetn = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("rel hld", hld_h_n, 2'b11);
        check("rel busy", busy, 1'b0);
        check("rel cfg", cfg_out, 8'h33);
        shift_bits(8, 16'h0081);
        do_load(1'b0);
        watch_hold("after rst", 8'h33, 8'h81, 1'b1);
        check("after rst cfg_out", cfg_out, 8'h81);
        check("after rst cfg_err", cfg_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
